// File: rtl/mp_sequencer_pkg.sv
// Shared definitions for the multiplier/ALU sequencer and its select stage:
// state encodings, instruction field positions and opcode constants.
package mp_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_INIT     = 4'd0,
    ST_OP_READ  = 4'd1,
    ST_OP_WAIT1 = 4'd2,
    ST_RA_READ  = 4'd3,
    ST_RB_READ  = 4'd4,
    ST_OP_WAIT2 = 4'd5,
    ST_OP_CAL   = 4'd6,
    ST_SELECT   = 4'd7,
    ST_RESULT   = 4'd8
  } state_e;

  localparam int FIELD_W     = 4;
  localparam int OPC_LSB     = 12;
  localparam int RD_LSB      = 8;
  localparam int RA_LSB      = 4;
  localparam int RB_LSB      = 0;
  localparam int OPC_MUL_BIT = 3;

  localparam logic [3:0] OPC_NOP = 4'h0;

  // Watchdog: exit is taken in the OP_CAL cycle whose count is 254, i.e. the 255th cycle.
  localparam int         WD_W    = 8;
  localparam logic [7:0] WD_LAST = 8'd254;

  function automatic logic is_mul(input logic [3:0] opc);
    return opc[OPC_MUL_BIT];
  endfunction

endpackage

// File: rtl/mp_sequencer_if.sv
// Instruction-memory read bus and multiplier start/done handshake of the sequencer.
interface mp_sequencer_if #(
  parameter int IA_W = 4
);
  logic            instr_re;
  logic [IA_W-1:0] instr_addr;
  logic [15:0]     instr_rdata;
  logic            mul_start;
  logic            mul_done;

  modport master (
    output instr_re, instr_addr, mul_start,
    input  instr_rdata, mul_done
  );

  modport slave (
    input  instr_re, instr_addr, mul_start,
    output instr_rdata, mul_done
  );
endinterface

// File: rtl/mp_instr_decode.sv
// Combinational field extraction of a 16-bit instruction word into opcode and
// register addresses (zero-extended or truncated to RA_W).
module mp_instr_decode
  import mp_sequencer_pkg::*;
#(
  parameter int RA_W = 4
) (
  input  logic [15:0]     instr,
  output logic [3:0]      opcode,
  output logic [RA_W-1:0] rd,
  output logic [RA_W-1:0] ra,
  output logic [RA_W-1:0] rb
);
  logic [FIELD_W-1:0] rd_f, ra_f, rb_f;

  assign opcode = instr[OPC_LSB +: FIELD_W];
  assign rd_f   = instr[RD_LSB +: FIELD_W];
  assign ra_f   = instr[RA_LSB +: FIELD_W];
  assign rb_f   = instr[RB_LSB +: FIELD_W];

  assign rd = RA_W'(rd_f);
  assign ra = RA_W'(ra_f);
  assign rb = RA_W'(rb_f);
endmodule

// File: rtl/mp_sequencer.sv
// Control FSM of the multiplier/ALU block: fetches instructions, sequences operand
// reads, starts/awaits the multiplier. Optional watchdog: MP_SEQUENCER_TIMEOUT_EN.
module mp_sequencer
  import mp_sequencer_pkg::*;
#(
  parameter int IA_W = 4,
  parameter int RA_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_start,
  input  logic            op_clear,
  input  logic [IA_W-1:0] instr_num,
  mp_sequencer_if.master  bus,
  output logic [3:0]      cur_state,
  output logic [3:0]      opcode,
  output logic [RA_W-1:0] rd_addr,
  output logic [RA_W-1:0] ra_addr,
  output logic [RA_W-1:0] rb_addr,
  output logic            busy,
  output logic            op_done
`ifdef MP_SEQUENCER_TIMEOUT_EN
  ,
  output logic            timeout_err
`endif
);

  state_e          state_q, state_d;
  logic [IA_W-1:0] pc_q, pc_d;
  logic            instr_re_q, instr_re_d;
  logic            mul_start_q, mul_start_d;
  logic [3:0]      opcode_q, opcode_d;
  logic [RA_W-1:0] rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
  logic [3:0]      dec_opcode;
  logic [RA_W-1:0] dec_rd, dec_ra, dec_rb;
`ifdef MP_SEQUENCER_TIMEOUT_EN
  logic [WD_W-1:0] wd_q, wd_d;
  logic            tmo_q, tmo_d;
`endif

  mp_instr_decode #(.RA_W(RA_W)) u_decode (
    .instr  (bus.instr_rdata),
    .opcode (dec_opcode),
    .rd     (dec_rd),
    .ra     (dec_ra),
    .rb     (dec_rb)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    rd_d     = rd_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
`ifdef MP_SEQUENCER_TIMEOUT_EN
    wd_d  = (state_q == ST_OP_CAL) ? wd_q + WD_W'(1) : '0;
    tmo_d = tmo_q;
`endif
    case (state_q)
      ST_INIT: begin
        pc_d = '0;
        if (op_start) state_d = ST_OP_READ;
      end
      ST_OP_READ:  state_d = ST_OP_WAIT1;
      // Read data is valid in this cycle; fields are held from RA_READ onwards.
      ST_OP_WAIT1: begin
        state_d  = ST_RA_READ;
        opcode_d = dec_opcode;
        rd_d     = dec_rd;
        ra_d     = dec_ra;
        rb_d     = dec_rb;
      end
      ST_RA_READ:  state_d = ST_RB_READ;
      ST_RB_READ:  state_d = ST_OP_WAIT2;
      ST_OP_WAIT2: state_d = ST_OP_CAL;
      ST_OP_CAL: begin
        if (!is_mul(opcode_q) || bus.mul_done) begin
          state_d = ST_SELECT;
        end
`ifdef MP_SEQUENCER_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          state_d = ST_RESULT;
          tmo_d   = 1'b1;
        end
`endif
      end
      ST_SELECT: begin
        if (pc_q == instr_num) begin
          state_d = ST_RESULT;
        end else begin
          pc_d    = pc_q + IA_W'(1);
          state_d = ST_OP_READ;
        end
      end
      ST_RESULT: begin
        if (op_start) begin
          pc_d    = '0;
          state_d = ST_OP_READ;
`ifdef MP_SEQUENCER_TIMEOUT_EN
          tmo_d   = 1'b0;
`endif
        end
      end
      default: state_d = ST_INIT;
    endcase

    if (op_clear) begin
      state_d = ST_INIT;
      pc_d    = '0;
    end
`ifdef MP_SEQUENCER_TIMEOUT_EN
    if (state_d == ST_INIT) tmo_d = 1'b0;
`endif

    // Strobes are registered, so they are derived from the next state.
    instr_re_d  = (state_d == ST_OP_READ);
    mul_start_d = (state_d == ST_OP_WAIT2) && is_mul(opcode_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      pc_q        <= '0;
      instr_re_q  <= 1'b0;
      mul_start_q <= 1'b0;
      opcode_q    <= OPC_NOP;
      rd_q        <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
`ifdef MP_SEQUENCER_TIMEOUT_EN
      wd_q        <= '0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_re_q  <= instr_re_d;
      mul_start_q <= mul_start_d;
      opcode_q    <= opcode_d;
      rd_q        <= rd_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
`ifdef MP_SEQUENCER_TIMEOUT_EN
      wd_q        <= wd_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign bus.instr_re   = instr_re_q;
  assign bus.instr_addr = pc_q;
  assign bus.mul_start  = mul_start_q;
  assign cur_state      = state_q;
  assign opcode         = opcode_q;
  assign rd_addr        = rd_q;
  assign ra_addr        = ra_q;
  assign rb_addr        = rb_q;
  assign busy           = (state_q != ST_INIT);
  assign op_done        = (state_q == ST_RESULT);
`ifdef MP_SEQUENCER_TIMEOUT_EN
  assign timeout_err    = tmo_q;
`endif

endmodule

// File: tb/tb_mp_sequencer.sv
// Testbench for mp_sequencer: expected per-cycle traces are built from the
// instruction list and multiplier latencies, then compared cycle by cycle.
module tb_mp_sequencer;

  logic       clk = 1'b0;
  logic       reset, op_start, op_clear;
  logic [3:0] instr_num;
  logic [3:0] cur_state, opcode, rd_addr, ra_addr, rb_addr;
  logic       busy, op_done;
`ifdef MP_SEQUENCER_TIMEOUT_EN
  logic       timeout_err;
`endif

  int checks = 0;
  int passed = 0;

  mp_sequencer_if #(.IA_W(4)) bus ();

  mp_sequencer #(.IA_W(4), .RA_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_start  (op_start),
    .op_clear  (op_clear),
    .instr_num (instr_num),
    .bus       (bus),
    .cur_state (cur_state),
    .opcode    (opcode),
    .rd_addr   (rd_addr),
    .ra_addr   (ra_addr),
    .rb_addr   (rb_addr),
    .busy      (busy),
    .op_done   (op_done)
`ifdef MP_SEQUENCER_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory with one cycle read latency, and a multiplier whose
  // done level appears lat cycles after the start pulse.
  logic [15:0] imem [16];
  int          lat_tab [16];
  int          mcnt = 0;
  bit          mul_never = 1'b0;

  always @(posedge clk) if (bus.instr_re) bus.instr_rdata <= imem[bus.instr_addr];
  always @(posedge clk) begin
    if (bus.mul_start) mcnt <= lat_tab[bus.instr_addr];
    else if (mcnt != 0) mcnt <= mcnt - 1;
  end
  assign bus.mul_done = (mcnt == 1) && !mul_never;

  typedef struct packed {
    logic [3:0]  st;
    logic        re;
    logic        ms;
    logic [3:0]  addr;
    logic [15:0] w;
  } exp_t;

  function automatic exp_t mk(input int st, input bit re, input bit ms, input int addr,
                              input logic [15:0] w);
    exp_t e;
    e.st = 4'(st); e.re = re; e.ms = ms; e.addr = 4'(addr); e.w = w;
    return e;
  endfunction

  // Runs program imem[0..n_last] from INIT or RESULT and checks every cycle.
  task automatic run_prog(input string name, input int n_last, input bit noise);
    exp_t        q[$];
    exp_t        e;
    logic [15:0] w;
    logic [11:0] got, want;
    int          k;
    for (int i = 0; i <= n_last; i++) begin
      w = imem[i];
      q.push_back(mk(1, 1, 0, i, w));
      q.push_back(mk(2, 0, 0, i, w));
      q.push_back(mk(3, 0, 0, i, w));
      q.push_back(mk(4, 0, 0, i, w));
      q.push_back(mk(5, 0, w[15], i, w));
      k = w[15] ? lat_tab[i] : 1;
      for (int c = 0; c < k; c++) q.push_back(mk(6, 0, 0, i, w));
      q.push_back(mk(7, 0, 0, i, w));
    end
    for (int c = 0; c < 3; c++) q.push_back(mk(8, 0, 0, n_last, imem[n_last]));
    instr_num = 4'(n_last);
    @(negedge clk); op_start = 1'b1;
    foreach (q[j]) begin
      @(negedge clk); op_start = 1'b0;
      e    = q[j];
      got  = {cur_state, bus.instr_re, bus.mul_start, bus.instr_addr, busy, op_done};
      want = {e.st, e.re, e.ms, e.addr, e.st != 4'd0, e.st == 4'd8};
      checks++;
      if (got !== want)
        $display("FAIL %s cyc%0d: got st=%0d re=%b ms=%b addr=%0d busy=%b done=%b, want st=%0d re=%b ms=%b addr=%0d busy=%b done=%b",
                 name, j, got[11:8], got[7], got[6], got[5:2], got[1], got[0],
                 want[11:8], want[7], want[6], want[5:2], want[1], want[0]);
      else passed++;
      if (e.st >= 4'd3) begin
        checks++;
        if ({opcode, rd_addr, ra_addr, rb_addr} !== e.w)
          $display("FAIL %s_decode cyc%0d: got %h want %h", name, j,
                   {opcode, rd_addr, ra_addr, rb_addr}, e.w);
        else passed++;
      end
      if (noise && e.st != 4'd8) op_start = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; op_start = 1'b1; op_clear = 1'b0; instr_num = 4'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cur_state, bus.instr_re, bus.instr_addr, bus.mul_start, opcode, rd_addr, ra_addr,
         rb_addr, busy, op_done} !== 28'd0)
      $display("FAIL reset_state: got st=%0d re=%b addr=%0d ms=%b opc=%h rd=%h ra=%h rb=%h busy=%b done=%b, want all 0",
               cur_state, bus.instr_re, bus.instr_addr, bus.mul_start, opcode, rd_addr,
               ra_addr, rb_addr, busy, op_done);
    else passed++;
    op_start = 1'b0; reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cur_state, busy} !== 5'd0)
      $display("FAIL idle_after_reset: got st=%0d busy=%b, want st=0 busy=0", cur_state, busy);
    else passed++;
  endtask

  task automatic test_alu_single();
    imem[0] = 16'h1234;
    run_prog("alu_1234", 0, 1'b0);
  endtask

  task automatic test_mul_single();
    imem[0] = 16'h8567; lat_tab[0] = 5;
    run_prog("mul_8567", 0, 1'b0);
  endtask

  task automatic test_multi();
    imem[0] = 16'h2abc; imem[1] = 16'h9123; imem[2] = 16'h0fed; lat_tab[1] = 3;
    run_prog("three_instr", 2, 1'b0);
  endtask

  task automatic test_nop();
    imem[0] = 16'h0000;
    run_prog("nop", 0, 1'b0);
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(0, 5);
      for (int i = 0; i <= n; i++) begin
        imem[i]    = 16'($urandom);
        lat_tab[i] = $urandom_range(1, 6);
      end
      run_prog($sformatf("rand%0d", r), n, 1'b1);
    end
  endtask

  task automatic test_abort_mid_mul(input bit use_reset);
    int n = 0;
    imem[0] = 16'h8abc; lat_tab[0] = 20; instr_num = 4'd0;
    @(negedge clk); op_start = 1'b1;
    @(negedge clk); op_start = 1'b0;
    while (cur_state != 4'd6 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (cur_state !== 4'd6) $display("FAIL abort_reach_opcal: got st=%0d want 6", cur_state);
    else passed++;
    repeat (2) @(negedge clk);
    if (use_reset) reset = 1'b1; else op_clear = 1'b1;
    @(negedge clk); reset = 1'b0; op_clear = 1'b0;
    checks++;
    if ({cur_state, bus.instr_addr, busy, bus.mul_start, bus.instr_re} !== 11'd0)
      $display("FAIL abort_%0d: got st=%0d pc=%0d busy=%b ms=%b re=%b, want all 0", use_reset,
               cur_state, bus.instr_addr, busy, bus.mul_start, bus.instr_re);
    else passed++;
    repeat (25) @(negedge clk);
    checks++;
    if (cur_state !== 4'd0) $display("FAIL abort_late_done_%0d: got st=%0d want 0", use_reset, cur_state);
    else passed++;
  endtask

`ifdef MP_SEQUENCER_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    imem[0] = 16'h8111; mul_never = 1'b1; instr_num = 4'd0;
    @(negedge clk); op_start = 1'b1;
    @(negedge clk); op_start = 1'b0;
    while (cur_state != 4'd6 && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (cur_state == 4'd6 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (n !== 255 || cur_state !== 4'd8 || timeout_err !== 1'b1)
      $display("FAIL timeout: got opcal_cycles=%0d st=%0d err=%b, want 255 8 1", n, cur_state, timeout_err);
    else passed++;
    @(negedge clk); op_clear = 1'b1;
    @(negedge clk); op_clear = 1'b0;
    checks++;
    if ({cur_state, timeout_err} !== 5'd0)
      $display("FAIL timeout_clear: got st=%0d err=%b, want 0 0", cur_state, timeout_err);
    else passed++;
    mul_never = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) begin imem[i] = 16'h0; lat_tab[i] = 1; end
    test_reset();
    test_alu_single();
    test_mul_single();
    test_multi();
    test_nop();
    test_random();
    test_abort_mid_mul(1'b0);
    test_abort_mid_mul(1'b1);
`ifdef MP_SEQUENCER_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mp_sequencer.md
Name: mp_sequencer

Overview:
- Control FSM of the multiplier/ALU processing block; produces `cur_state`, the decoded `opcode` and register addresses consumed by the select stage, ALU, multiplier and register file.
- Fetches 16-bit instructions from instruction memory and sequences operand reads.
- Starts the multiplier and waits for it, then steps the select stage through SELECT and RESULT.

Parameters:
- IA_W, 4, instruction address width (program length up to 2^IA_W).
- RA_W, 4, register-file address width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- op_start  input  1  one-cycle pulse: start program execution from address 0.
- op_clear  input  1  abort; return to INIT from any state.
- instr_num  input  IA_W  index of last instruction to execute (inclusive).
- instr_rdata  input  16  instruction word; valid one cycle after instr_re.
- mul_done  input  1  multiplier result valid (level).
- instr_re  output  1  instruction memory read enable.
- instr_addr  output  IA_W  program counter.
- cur_state  output  4  current state encoding.
- opcode  output  4  decoded opcode, held from RA_READ through SELECT.
- rd_addr, ra_addr, rb_addr  output  RA_W each  decoded register addresses.
- mul_start  output  1  one-cycle multiplier start pulse.
- busy  output  1  high in every state except INIT.
- op_done  output  1  high while in RESULT.

Behaviour:
- Reset: state INIT; PC 0; opcode and addresses 0; all strobes 0; busy 0.
- Instruction word format: [15:12] opcode, [11:8] rd, [7:4] ra, [3:0] rb. Addresses are zero-extended or truncated to RA_W.
- State encodings: INIT 0, OP_READ 1, OP_WAIT1 2, RA_READ 3, RB_READ 4, OP_WAIT2 5, OP_CAL 6, SELECT 7, RESULT 8. Codes 9–15 are unused and go to INIT next cycle.
- INIT: PC held at 0. On `op_start` go to OP_READ.
- OP_READ: `instr_re`=1, `instr_addr`=PC. Go to OP_WAIT1.
- OP_WAIT1: memory latency cycle. Go to RA_READ.
- RA_READ: latch `instr_rdata` into opcode/rd/ra/rb. Go to RB_READ.
- RB_READ: go to OP_WAIT2 (register-file read latency).
- OP_WAIT2: if opcode[3]=1, pulse `mul_start` for exactly one cycle. Go to OP_CAL.
- OP_CAL:
  - opcode[3]=0: one cycle, then SELECT.
  - opcode[3]=1: stay until `mul_done`=1, then SELECT. A `mul_done` already high on OP_CAL entry is accepted.
- SELECT: exactly one cycle. Next:
  - PC == instr_num: go to RESULT, PC unchanged.
  - otherwise: PC+1 (wraps mod 2^IA_W), go to OP_READ.
- NOP (opcode 0) traverses all states; the select stage suppresses the write.
- RESULT: `op_done`=1. Stay until `op_start` (restart: PC 0, go to OP_READ) or `op_clear` (go to INIT).
- `op_clear` priority: highest except `reset`. From any state it goes to INIT, clears PC, drops `mul_start`.
- `op_start` is ignored outside INIT and RESULT.
- `reset` mid-multiply: INIT next cycle. The multiplier is not notified; its `mul_done` is ignored in INIT.
- Outputs are registered except `cur_state`, `busy` and `op_done`, which decode directly from the state register.

Optional Feature:
- MP_SEQUENCER_TIMEOUT_EN:
  - Defined: adds an 8-bit watchdog counter, cleared on OP_CAL entry and incremented each OP_CAL cycle. At count 255 without `mul_done`, go to RESULT with extra output `timeout_err`=1. `timeout_err` is sticky until INIT or restart.
  - Undefined: no counter, no port; OP_CAL waits indefinitely.

Decomposition:
- Shared package: the 4-bit state encodings (also used by the select stage), instruction-field bit positions, and NOP/opcode[3] multiply-select constants.
- One sub-module is natural: mp_instr_decode (combinational field extraction). The FSM and PC stay in mp_sequencer.

Test Plan:
- reset, then `op_start` with `instr_num`=0, instruction 16'h1234 (ALU): states 1,2,3,4,5,6,7,8 on consecutive cycles; opcode=1, rd=2, ra=3, rb=4; `op_done` high from the 8th cycle after start.
- Instruction 16'h8567 (multiply), `mul_done` raised 5 cycles after the `mul_start` pulse: `mul_start` high exactly 1 cycle in OP_WAIT2; OP_CAL held 5 cycles; SELECT once.
- `instr_num`=2, three instructions: `instr_addr` steps 0,1,2; RESULT entered after the third SELECT; no fourth fetch.
- `op_clear` asserted during OP_CAL while a multiply is waiting: INIT next cycle, PC 0, `busy` 0.
- Instruction 16'h0000 (NOP): full state traversal, `mul_start` never asserted.
- With MP_SEQUENCER_TIMEOUT_EN, multiply with `mul_done` held 0: RESULT 255 OP_CAL cycles after entry, `timeout_err`=1.
